// File: rtl/uart_tx_param_if.sv
// Parallel-side handshake for uart_tx_param: word, valid/ready and optional parity select.
// The parity_odd signal exists only when UART_TX_PARITY_EN is defined.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 valid;
  logic                 ready;
`ifdef UART_TX_PARITY_EN
  logic                 parity_odd;

  modport master (output din, output valid, output parity_odd, input ready);
  modport slave  (input din, input valid, input parity_odd, output ready);
`else
  modport master (output din, output valid, input ready);
  modport slave  (input din, input valid, output ready);
`endif
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits, each bit held OVERSAMPLE baud_clk cycles. Parity via UART_TX_PARITY_EN.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic             baud_clk,
  input  logic             reset,
  uart_tx_param_if.slave   bus,
  output logic             sending,
  output logic             tx_done,
  output logic             out
);

  localparam int OS_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 2) begin : g_bad_oversample
    $error("uart_tx_param: OVERSAMPLE must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 out_d;
  logic                 sending_d;
  logic                 tx_done_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign bus.ready = (state_q == IDLE);
  assign bit_end   = (os_cnt_q == OS_LAST);

  // bit_idx counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    out_d     = out;
    sending_d = sending;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        out_d     = 1'b1;
        sending_d = 1'b0;
        if (bus.valid) begin
          shift_d   = bus.din;
          os_cnt_d  = '0;
          bit_idx_d = '0;
          state_d   = START;
          out_d     = 1'b0;
          sending_d = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^bus.din) ^ bus.parity_odd;
`endif
        end
      end

      START: begin
        if (bit_end) begin
          os_cnt_d = '0;
          out_d    = shift_q[0];
          shift_d  = shift_q >> 1;
          state_d  = DATA;
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          os_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            out_d     = parity_q;
            state_d   = PARITY;
`else
            out_d     = 1'b1;
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            out_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          os_cnt_d  = '0;
          bit_idx_d = '0;
          out_d     = 1'b1;
          state_d   = STOP;
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          os_cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            out_d     = 1'b1;
            sending_d = 1'b0;
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        os_cnt_d  = '0;
        bit_idx_d = '0;
        out_d     = 1'b1;
        sending_d = 1'b0;
      end
    endcase
  end

  // Reset abandons any frame in flight and parks the line high immediately
  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      out       <= 1'b1;
      sending   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      out       <= out_d;
      sending   <= sending_d;
      tx_done   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed testbench for uart_tx_param: three instances (8N1/16x, 7 data 2 stop, 4x oversample).
// Expected frames are hand-written bit strings; parity bits are included when UART_TX_PARITY_EN is set.
module tb_uart_tx_param;

  logic baud_clk = 1'b0;
  logic reset;

  always #5 baud_clk = ~baud_clk;

  uart_tx_param_if #(.DATA_BITS(8)) bus_def ();
  uart_tx_param_if #(.DATA_BITS(7)) bus_7 ();
  uart_tx_param_if #(.DATA_BITS(8)) bus_4 ();

  logic out_def, sending_def, done_def;
  logic out_7, sending_7, done_7;
  logic out_4, sending_4, done_4;

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16)) dut_def (
    .baud_clk (baud_clk),
    .reset    (reset),
    .bus      (bus_def),
    .sending  (sending_def),
    .tx_done  (done_def),
    .out      (out_def)
  );

  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLE(16)) dut_7 (
    .baud_clk (baud_clk),
    .reset    (reset),
    .bus      (bus_7),
    .sending  (sending_7),
    .tx_done  (done_7),
    .out      (out_7)
  );

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(4)) dut_4 (
    .baud_clk (baud_clk),
    .reset    (reset),
    .bus      (bus_4),
    .sending  (sending_4),
    .tx_done  (done_4),
    .out      (out_4)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int sel      = 0;

  logic obs_out, obs_sending, obs_done, obs_ready;

  always_comb begin
    obs_out     = out_def;
    obs_sending = sending_def;
    obs_done    = done_def;
    obs_ready   = bus_def.ready;
    case (sel)
      1: begin
        obs_out     = out_7;
        obs_sending = sending_7;
        obs_done    = done_7;
        obs_ready   = bus_7.ready;
      end
      2: begin
        obs_out     = out_4;
        obs_sending = sending_4;
        obs_done    = done_4;
        obs_ready   = bus_4.ready;
      end
      default: ;
    endcase
  end

  // Start bit, data LSB first, parity character only in the parity build, then stop bits
  function automatic string frame_str(string data, string par, string stops);
`ifdef UART_TX_PARITY_EN
    return {"0", data, par, stops};
`else
    if (par.len() > 1) return "";
    return {"0", data, stops};
`endif
  endfunction

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(int which, logic [7:0] data, bit hold);
    @(negedge baud_clk);
    case (which)
      1: begin bus_7.din = data[6:0]; bus_7.valid = 1'b1; end
      2: begin bus_4.din = data;      bus_4.valid = 1'b1; end
      default: begin bus_def.din = data; bus_def.valid = 1'b1; end
    endcase
    @(posedge baud_clk);
    #1;
    if (!hold) begin
      bus_def.valid = 1'b0;
      bus_7.valid   = 1'b0;
      bus_4.valid   = 1'b0;
    end
  endtask

  // Called just after the accept edge; walks every cycle of the frame, then the done cycle
  task automatic check_frame(string tag, string bits, int os);
    logic exp_bit;
    for (int b = 0; b < bits.len(); b++) begin
      for (int c = 0; c < os; c++) begin
        @(negedge baud_clk);
        exp_bit = (bits[b] == "1");
        check_output($sformatf("%s_out_b%0d_c%0d", tag, b, c), 32'(obs_out), 32'(exp_bit));
        check_output($sformatf("%s_sending_b%0d_c%0d", tag, b, c), 32'(obs_sending), 32'd1);
        check_output($sformatf("%s_ready_b%0d_c%0d", tag, b, c), 32'(obs_ready), 32'd0);
        check_output($sformatf("%s_done_b%0d_c%0d", tag, b, c), 32'(obs_done), 32'd0);
      end
    end
    @(negedge baud_clk);
    check_output({tag, "_done_end"}, 32'(obs_done), 32'd1);
    check_output({tag, "_sending_end"}, 32'(obs_sending), 32'd0);
    check_output({tag, "_ready_end"}, 32'(obs_ready), 32'd1);
    check_output({tag, "_out_end"}, 32'(obs_out), 32'd1);
  endtask

  initial begin
    reset         = 1'b0;
    bus_def.din   = '0;
    bus_def.valid = 1'b0;
    bus_7.din     = '0;
    bus_7.valid   = 1'b0;
    bus_4.din     = '0;
    bus_4.valid   = 1'b0;
`ifdef UART_TX_PARITY_EN
    bus_def.parity_odd = 1'b0;
    bus_7.parity_odd   = 1'b0;
    bus_4.parity_odd   = 1'b0;
`endif

    repeat (3) @(negedge baud_clk);
    check_output("rst_out", 32'(out_def), 32'd1);
    check_output("rst_sending", 32'(sending_def), 32'd0);
    check_output("rst_done", 32'(done_def), 32'd0);
    check_output("rst_ready", 32'(bus_def.ready), 32'd1);
    check_output("rst_out_7", 32'(out_7), 32'd1);
    check_output("rst_ready_4", 32'(bus_4.ready), 32'd1);
    reset = 1'b1;
    @(negedge baud_clk);
    $display("[TB] reset released");

    // 8'h55, single-cycle valid
    sel = 0;
    apply_stimulus(0, 8'h55, 1'b0);
    check_frame("t1", frame_str("10101010", "0", "1"), 16);
    @(negedge baud_clk);
    check_output("t1_done_single", 32'(done_def), 32'd0);

`ifdef UART_TX_PARITY_EN
    bus_def.parity_odd = 1'b1;
    apply_stimulus(0, 8'h55, 1'b0);
    bus_def.parity_odd = 1'b0;
    check_frame("t2_odd55", frame_str("10101010", "1", "1"), 16);
    apply_stimulus(0, 8'h07, 1'b0);
    check_frame("t2_even07", frame_str("11100000", "1", "1"), 16);
`endif

    // valid held high across two frames; din changes mid-frame
    apply_stimulus(0, 8'hA5, 1'b1);
    bus_def.din = 8'h3C;
    check_frame("t4_a5", frame_str("10100101", "0", "1"), 16);
    @(posedge baud_clk);
    #1;
    bus_def.valid = 1'b0;
    check_frame("t4_3c", frame_str("00111100", "0", "1"), 16);
    @(negedge baud_clk);
    check_output("t4_idle_out", 32'(out_def), 32'd1);
    check_output("t4_idle_sending", 32'(sending_def), 32'd0);

    // reset in the middle of a frame
    apply_stimulus(0, 8'h55, 1'b0);
    repeat (70) @(negedge baud_clk);
    check_output("t5_pre_out", 32'(out_def), 32'd0);
    check_output("t5_pre_sending", 32'(sending_def), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_output("t5_rst_out", 32'(out_def), 32'd1);
    check_output("t5_rst_sending", 32'(sending_def), 32'd0);
    check_output("t5_rst_ready", 32'(bus_def.ready), 32'd1);
    check_output("t5_rst_done", 32'(done_def), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge baud_clk);
      check_output($sformatf("t5_hold_done_%0d", i), 32'(done_def), 32'd0);
    end
    reset = 1'b1;
    @(negedge baud_clk);
    check_output("t5_post_done", 32'(done_def), 32'd0);
    apply_stimulus(0, 8'hFF, 1'b0);
    check_frame("t5_ff", frame_str("11111111", "0", "1"), 16);

    // 7 data bits, 2 stop bits
    sel = 1;
    apply_stimulus(1, 8'h41, 1'b0);
    check_frame("t3_41", frame_str("1000001", "0", "11"), 16);

    // 4x oversample
    sel = 2;
    apply_stimulus(2, 8'h01, 1'b0);
    check_frame("t6_01", frame_str("10000000", "1", "1"), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
